// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the register file.
package regfile_pkg;

    parameter int unsigned DATA_W    = 32;
    parameter int unsigned ADDR_W    = 5;
    parameter int unsigned REG_COUNT = 1 << ADDR_W;
    parameter int unsigned ZERO_REG  = 0;

    typedef logic [DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address mux, register 0 forced to zero, and
// optional same-cycle write forwarding (enabled by macro REGFILE_BYPASS_EN).
module reg_file_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                  addr_i,
    input  logic                               wr_en_i,
    input  logic [ADDR_W-1:0]                  wr_addr_i,
    input  logic [DATA_W-1:0]                  wr_data_i,
    output logic [DATA_W-1:0]                  dout_o
);

    logic addr_is_zero;
    assign addr_is_zero = (addr_i == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;
    // wr_en_i already excludes reset, so forwarding is suppressed while reset is held
    assign bypass_hit = wr_en_i && (addr_i == wr_addr_i) && !addr_is_zero;
`else
    logic bypass_hit;
    logic unused_bypass;
    assign bypass_hit    = 1'b0;
    assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    // Select forwarded data, zero for register 0, else stored contents
    always_comb begin
        dout_o = regs_i[addr_i];
        if (addr_is_zero) begin
            dout_o = '0;
        end else if (bypass_hit) begin
            dout_o = wr_data_i;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 2^ADDR_W x DATA_W register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero. Write-to-read
// forwarding is compiled in with macro REGFILE_BYPASS_EN.
module reg_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] din,
    input  logic              regWrite,
    output logic [DATA_W-1:0] dout1,
    output logic [DATA_W-1:0] dout2
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [NumRegs-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                           wr_en;

    // A write held during reset must neither store nor forward
    assign wr_en = regWrite && rst;

    // Next-state storage: one register updated, writes to register 0 dropped
    always_comb begin
        regs_d = regs_q;
        if (regWrite && (addr3 != ADDR_W'(ZERO_REG))) begin
            regs_d[addr3] = din;
        end
    end

    // Storage with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port1 (
        .regs_i    (regs_q),
        .addr_i    (addr1),
        .wr_en_i   (wr_en),
        .wr_addr_i (addr3),
        .wr_data_i (din),
        .dout_o    (dout1)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port2 (
        .regs_i    (regs_q),
        .addr_i    (addr2),
        .wr_en_i   (wr_en),
        .wr_addr_i (addr3),
        .wr_data_i (din),
        .dout_o    (dout2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios with literal
// expectations plus randomized traffic against an array-based model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  addr1 = '0;
    logic [4:0]  addr2 = '0;
    logic [4:0]  addr3 = '0;
    logic [31:0] din = '0;
    logic        regWrite = 1'b0;
    logic [31:0] dout1;
    logic [31:0] dout2;

    int vectors = 0;
    int miscompares = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    bit [31:0] mem [32];

    reg_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr1    (addr1),
        .addr2    (addr2),
        .addr3    (addr3),
        .din      (din),
        .regWrite (regWrite),
        .dout1    (dout1),
        .dout2    (dout2)
    );

    always #5 clk = ~clk;

    // Reference model: array of registers, cleared by reset, written at edges
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else if (regWrite && addr3 != 5'd0) begin
            mem[addr3] = din;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (!rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (Bypass && regWrite && a == addr3) return din;
        return mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Continuous comparison midway between rising edges
    always @(negedge clk) begin
        check("model_dout1", dout1, model_read(addr1));
        check("model_dout2", dout2, model_read(addr2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles, released away from an edge
        step();
        step();
        rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            addr1 = 5'(a);
            addr2 = 5'(31 - a);
            #1;
            check("reset_clear", dout1, 32'h0);
        end
        step();

        // Write to register 0 is discarded, including during the write cycle
        addr3 = 5'd0; din = 32'h1234_5678; regWrite = 1'b1; addr1 = 5'd0;
        #1 check("r0_during_write", dout1, 32'h0);
        step();
        regWrite = 1'b0;
        #1 check("r0_after_write", dout1, 32'h0);

        // Basic write then read
        addr3 = 5'd1; din = 32'h1111_1111; regWrite = 1'b1;
        step();
        regWrite = 1'b0; addr1 = 5'd0; addr2 = 5'd1;
        #1;
        check("basic_dout1", dout1, 32'h0);
        check("basic_dout2", dout2, 32'h1111_1111);

        // Port 1 forwarding (old value 0 without forwarding)
        addr1 = 5'd2; addr3 = 5'd2; din = 32'h2222_2222; regWrite = 1'b1;
        #1 check("bypass1_before_edge", dout1, Bypass ? 32'h2222_2222 : 32'h0);
        step();
        regWrite = 1'b0;
        #1 check("bypass1_after_edge", dout1, 32'h2222_2222);

        // Dual forwarding, then a disabled write leaves the register alone
        addr1 = 5'd5; addr2 = 5'd5; addr3 = 5'd5; din = 32'hDEAD_BEEF; regWrite = 1'b1;
        #1;
        check("dual_bypass_dout1", dout1, Bypass ? 32'hDEAD_BEEF : 32'h0);
        check("dual_bypass_dout2", dout2, Bypass ? 32'hDEAD_BEEF : 32'h0);
        step();
        regWrite = 1'b0; din = 32'hFFFF_FFFF;
        step();
        #1;
        check("wr_disable_dout1", dout1, 32'hDEAD_BEEF);
        check("wr_disable_dout2", dout2, 32'hDEAD_BEEF);

        // Asynchronous reset between edges
        addr3 = 5'd31; din = 32'hA5A5_A5A5; regWrite = 1'b1;
        step();
        regWrite = 1'b0; addr1 = 5'd31;
        #1 check("r31_written", dout1, 32'hA5A5_A5A5);
        #1 rst = 1'b0;
        #1 check("async_reset_clear", dout1, 32'h0);
        step();
        step();
        rst = 1'b1;
        #1 check("after_reset_release", dout1, 32'h0);

        // Randomized traffic; the negedge process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst) rst = 1'b1;
            addr1 = 5'($urandom_range(0, 31));
            addr2 = 5'($urandom_range(0, 31));
            addr3 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) addr1 = addr3;
            if ($urandom_range(0, 3) == 0) addr2 = addr3;
            din = $urandom;
            regWrite = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
            end
        end
        step();
        regWrite = 1'b0;
        rst = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
